// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with valid/ready handshake and a two-entry skid buffer.
// It also inserts flush bubbles and keeps a saturating count of back-pressure cycles.
module if_id_skid_stage #(
    parameter int                INS_W    = 32,
    parameter int                PC_W     = 32,
    parameter int                DATA_W   = 8,
    parameter logic [PC_W-1:0]   PC_RESET = PC_W'(32'h00003000),
    parameter int                STALL_W  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INS_W-1:0]   in_ins,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INS_W-1:0]   out_ins,
    output logic [PC_W-1:0]    out_pc,
    output logic [DATA_W-1:0]  out_data,
    output logic [STALL_W-1:0] stall_cnt
);

    logic               r_main_valid;
    logic [INS_W-1:0]   r_main_ins;
    logic [PC_W-1:0]    r_main_pc;
    logic [DATA_W-1:0]  r_main_data;
    logic               r_skid_valid;
    logic [INS_W-1:0]   r_skid_ins;
    logic [PC_W-1:0]    r_skid_pc;
    logic [DATA_W-1:0]  r_skid_data;
    logic [STALL_W-1:0] r_stall_cnt;

    logic w_acc;
    logic w_con;
    logic w_stall;

    // in_ready depends only on registered skid state, never on out_ready.
    assign w_acc   = in_valid & ~r_skid_valid;
    assign w_con   = r_main_valid & out_ready;
    assign w_stall = r_main_valid & ~out_ready & (r_stall_cnt != {STALL_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_main_valid <= 1'b0;
            r_main_ins   <= '0;
            r_main_pc    <= PC_RESET;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ins   <= '0;
            r_skid_pc    <= '0;
            r_skid_data  <= '0;
            r_stall_cnt  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_ins   <= '0;
            r_main_pc    <= PC_RESET;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            if (!r_main_valid || w_con) begin
                // Main slot is free this cycle: refill from skid first to keep FIFO order.
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_ins   <= r_skid_ins;
                    r_main_pc    <= r_skid_pc;
                    r_main_data  <= r_skid_data;
                    r_skid_valid <= 1'b0;
                end else if (w_acc) begin
                    r_main_valid <= 1'b1;
                    r_main_ins   <= in_ins;
                    r_main_pc    <= in_pc;
                    r_main_data  <= in_data;
                end else begin
                    // Bubble: NOP payload, PC keeps the last consumed value.
                    r_main_valid <= 1'b0;
                    r_main_ins   <= '0;
                    r_main_data  <= '0;
                end
            end else if (w_acc) begin
                r_skid_valid <= 1'b1;
                r_skid_ins   <= in_ins;
                r_skid_pc    <= in_pc;
                r_skid_data  <= in_data;
            end

            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_ins   = r_main_ins;
    assign out_pc    = r_main_pc;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised successor of the IF/ID pipeline register.
- Carries instruction, PC and an optional sideband payload from fetch to decode.
- Uses a valid/ready handshake and a 2-entry skid buffer, so a decode-side stall never drops or duplicates a fetched word.
- Supports flush (bubble insertion on branch/exception) and counts back-pressure cycles for performance monitoring.

Parameters:
- INS_W, 32: instruction width.
- PC_W, 32: PC width.
- DATA_W, 8: sideband payload width (e.g. exception code, predicted-taken bit); must be ≥ 1.
- PC_RESET, 32'h00003000: PC value loaded on reset and flush.
- STALL_W, 16: width of the stall counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset_n, input, 1: synchronous active-low reset.
- flush, input, 1: synchronous clear of the stage contents.
- in_valid, input, 1: fetch presents a word.
- in_ready, output, 1: stage can accept a word; registered, equals !skid_valid.
- in_ins, input, INS_W: fetched instruction.
- in_pc, input, PC_W: PC of the fetched instruction.
- in_data, input, DATA_W: sideband payload.
- out_valid, output, 1: decode-facing word is valid.
- out_ready, input, 1: decode consumes the word this cycle.
- out_ins, output, INS_W: instruction to decode.
- out_pc, output, PC_W: PC to decode.
- out_data, output, DATA_W: payload to decode.
- stall_cnt, output, STALL_W: saturating count of back-pressure cycles.

Behaviour:
- Storage: main entry (drives out_*) and skid entry, each holding {valid, ins, pc, data}.
- Accept: acc = in_valid & in_ready. Consume: con = out_valid & out_ready.
- Priority: reset_n low > flush > normal operation.
- Reset (reset_n=0 at the edge):
  - both valids 0; out_ins=0, out_pc=PC_RESET, out_data=0.
  - skid payload cleared; stall_cnt=0.
  - in_ready reads 1 after the edge.
- Flush (flush=1, reset_n=1):
  - both valids 0; out_ins=0, out_data=0, out_pc=PC_RESET.
  - A word offered in the flush cycle is discarded even if acc=1.
  - stall_cnt is held (not cleared, not incremented).
- Normal update, evaluated on the current state:
  - Main empty, skid empty, acc: input → main. Latency in→out = 1 cycle.
  - Main full, con, skid empty, acc: input → main (back-to-back streaming, full throughput).
  - Main full, con, skid empty, no acc: main empties; out_ins←0, out_data←0, out_pc holds its last value.
  - Main full, !con, skid empty, acc: input → skid; in_ready=0 next cycle.
  - Main full, con, skid full: skid → main, skid empties; in_ready=1 next cycle. No acc is possible in this cycle (in_ready=0).
  - Main full, !con, skid full: hold everything.
  - Main empty, skid full: unreachable; the verifier asserts this never occurs.
- out_valid=0 ⇒ out_ins=0 and out_data=0 at all times after reset (decode sees a NOP bubble).
- Ordering is strict FIFO; no word is lost or duplicated except by flush or reset.
- stall_cnt: increments by 1 on each cycle with out_valid=1 & out_ready=0 & flush=0. Saturates at all-ones; no wrap.
- Outputs are registered only; no combinational path from out_ready to in_ready.
- Reset asserted mid-stall (skid full): both entries are dropped; the next cycle behaves as post-reset.

Test Plan:
- Reset then stream: reset_n=0 for 2 cycles, then in_valid=1 with ins 0x1000_0001.. and pc 0x3000,0x3004.., out_ready=1 → after reset out_pc=0x3000 and out_ins=0. Each word appears on out_* exactly 1 cycle after accept. in_ready stays 1; stall_cnt=0.
- Back-pressure skid: main holds pc 0x3004; drop out_ready for 3 cycles while in_valid=1 → pc 0x3008 goes to skid; in_ready=0 from the next cycle. stall_cnt=3. On release, 0x3004 then 0x3008 then 0x300C appear, no gaps or duplicates.
- Flush with full skid: main=0x3010, skid=0x3014, assert flush with in_valid=1 (pc 0x3018) → next cycle out_valid=0, out_ins=0, out_pc=0x3000, in_ready=1. 0x3018 never appears on the outputs.
- Flush and reset together: flush=1 and reset_n=0 in the same cycle → reset values appear, including stall_cnt=0 (reset wins).
- Counter saturation with STALL_W=4: hold out_ready=0 for 20 cycles with out_valid=1 → stall_cnt reaches 15 and stays at 15.
- Drain bubble: single word 0x0000_0020 at pc 0x3040, consumed with no follow-up input → next cycle out_valid=0, out_ins=0, out_data=0, out_pc=0x3040.
